// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data-memory arbiter slice.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;

    // Which master a pending read response belongs to.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

endpackage

// File: rtl/dmem_arb_core.sv
// Grant/priority logic for the two dmem masters: fixed priority to m0,
// a starvation guard for m1, and a bounded m1 burst lock.
module dmem_arb_core #(
    parameter int STARVE_LIM = 4,
    parameter int MAX_LOCK   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic m0_req,
    input  logic m1_req,
    input  logic m1_lock,
    output logic m0_gnt,
    output logic m1_gnt
);

    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam int LW = $clog2(MAX_LOCK + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
    localparam logic [LW-1:0] LOCK_MAX   = LW'(MAX_LOCK);

    logic [SW-1:0] starve_cnt;
    logic [LW-1:0] lock_cnt;
    logic          prev_m1;
    logic          locked;
    logic          starved;

    // Priority decision; grants are forced low while reset is asserted so
    // nothing reaches dmem during reset.
    always_comb begin
        m0_gnt  = 1'b0;
        m1_gnt  = 1'b0;
        locked  = m1_lock & m1_req & prev_m1 & (lock_cnt < LOCK_MAX);
        starved = m1_req & (starve_cnt >= STARVE_MAX);
        if (rst) begin
            if (locked | starved) begin
                m1_gnt = 1'b1;
            end else if (m0_req) begin
                m0_gnt = 1'b1;
            end else if (m1_req) begin
                m1_gnt = 1'b1;
            end
        end
    end

    // Starvation and burst-lock bookkeeping. lock_cnt saturates at MAX_LOCK
    // so an expired lock stays expired until m0 wins or the burst ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            lock_cnt   <= '0;
            prev_m1    <= 1'b0;
        end else begin
            prev_m1 <= m1_gnt;

            if (m1_gnt || !m1_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            if (m1_gnt && m1_lock) begin
                if (lock_cnt != LOCK_MAX) begin
                    lock_cnt <= lock_cnt + LW'(1);
                end
            end else begin
                lock_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem between the CPU LSU (m0) and the debug /
// program-loader port (m1). Adds the request mux and read-response routing
// around the grant core.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int STARVE_LIM = 4,
    parameter int MAX_LOCK   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_be,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_be,
    input  logic                m1_lock,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);

    owner_e              rsp_owner;
    logic [DATA_W-1:0]   m0_hold;
    logic [DATA_W-1:0]   m1_hold;

    dmem_arb_core #(
        .STARVE_LIM (STARVE_LIM),
        .MAX_LOCK   (MAX_LOCK)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .m0_req  (m0_req),
        .m1_req  (m1_req),
        .m1_lock (m1_lock),
        .m0_gnt  (m0_gnt),
        .m1_gnt  (m1_gnt)
    );

    assign mem_en = m0_gnt | m1_gnt;

    // Drive dmem with the winner's fields; all zero when nobody is granted.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (m1_gnt) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_be    = m1_be;
        end else if (m0_gnt) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_be    = m0_be;
        end
    end

    // Tag each granted read with its owner so the data returning one cycle
    // later goes to the right master; writes leave no tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_owner <= OWN_NONE;
        end else if (mem_en && !mem_we) begin
            rsp_owner <= m1_gnt ? OWN_M1 : OWN_M0;
        end else begin
            rsp_owner <= OWN_NONE;
        end
    end

    assign m0_rvalid = (rsp_owner == OWN_M0);
    assign m1_rvalid = (rsp_owner == OWN_M1);

    // Remember the last delivered word per master so rdata holds between
    // responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0_hold <= '0;
            m1_hold <= '0;
        end else begin
            if (m0_rvalid) m0_hold <= mem_rdata;
            if (m1_rvalid) m1_hold <= mem_rdata;
        end
    end

    assign m0_rdata = m0_rvalid ? mem_rdata : m0_hold;
    assign m1_rdata = m1_rvalid ? mem_rdata : m1_hold;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, directed corner sequences and a
// random run, all compared against a behavioural model of the arbiter.
module tb_dmem_arbiter;

    localparam int STARVE_LIM = 4;
    localparam int MAX_LOCK   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic [3:0]  m0_be = 0, m1_be = 0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIM(STARVE_LIM), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_be(m0_be), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_be(m1_be), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] init_word(int i);
        return (i == 1) ? 32'h0000_002A : 32'h0000_1000 + 32'(i);
    endfunction

    // Synchronous dmem device with one cycle of read latency.
    logic [31:0] tb_mem [64];
    bit          mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) tb_mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= tb_mem[mem_addr[7:2]];
            end
        end
    end

    // Reference model state
    int          checks = 0, failures = 0;
    logic [31:0] ref_mem [64];
    int          m1_wait, burst, rsp_who;
    bit          prev_m1, exp_g0, exp_g1;
    logic [31:0] rsp_data, exp_rd0, exp_rd1;

    // Observed outputs from the most recent step
    logic        obs_g0, obs_g1, obs_en, obs_we, obs_rv0, obs_rv1;
    logic [31:0] obs_addr, obs_wdata, obs_rd0, obs_rd1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m1_wait = 0; burst = 0; rsp_who = 0; prev_m1 = 0;
        exp_g0 = 0; exp_g1 = 0; exp_rd0 = 0; exp_rd1 = 0; rsp_data = 0;
    endtask

    // One clock cycle: inputs already applied at posedge+1; compare mid-cycle,
    // then advance the model across the edge.
    task automatic step();
        bit          w1, e_we;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        #3;
        w1 = m1_req && ((m1_lock && prev_m1 && burst < MAX_LOCK) ||
                        m1_wait >= STARVE_LIM || !m0_req);
        exp_g1 = w1;
        exp_g0 = m0_req && !w1;
        e_we = 0; e_addr = 0; e_wdata = 0; e_be = 0;
        if (exp_g1) begin
            e_we = m1_we; e_addr = m1_addr; e_wdata = m1_wdata; e_be = m1_be;
        end else if (exp_g0) begin
            e_we = m0_we; e_addr = m0_addr; e_wdata = m0_wdata; e_be = m0_be;
        end
        if (rsp_who == 1) exp_rd0 = rsp_data;
        if (rsp_who == 2) exp_rd1 = rsp_data;

        obs_g0 = m0_gnt; obs_g1 = m1_gnt; obs_en = mem_en; obs_we = mem_we;
        obs_addr = mem_addr; obs_wdata = mem_wdata;
        obs_rv0 = m0_rvalid; obs_rv1 = m1_rvalid; obs_rd0 = m0_rdata; obs_rd1 = m1_rdata;

        chk("m0_gnt", m0_gnt, exp_g0);
        chk("m1_gnt", m1_gnt, exp_g1);
        chk("mem_en", mem_en, exp_g0 | exp_g1);
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("mem_be", mem_be, e_be);
        chk("m0_rvalid", m0_rvalid, rsp_who == 1);
        chk("m1_rvalid", m1_rvalid, rsp_who == 2);
        chk("m0_rdata", m0_rdata, exp_rd0);
        chk("m1_rdata", m1_rdata, exp_rd1);

        @(posedge clk);
        rsp_who = 0;
        if (exp_g0 || exp_g1) begin
            if (e_we) begin
                for (int b = 0; b < 4; b++)
                    if (e_be[b]) ref_mem[e_addr[7:2]][8*b +: 8] = e_wdata[8*b +: 8];
            end else begin
                rsp_who  = exp_g1 ? 2 : 1;
                rsp_data = ref_mem[e_addr[7:2]];
            end
        end
        if (exp_g1 || !m1_req) m1_wait = 0;
        else m1_wait = (m1_wait + 1 > STARVE_LIM) ? STARVE_LIM : m1_wait + 1;
        if (exp_g1 && m1_lock) burst = (burst + 1 > MAX_LOCK) ? MAX_LOCK : burst + 1;
        else burst = 0;
        prev_m1 = exp_g1;
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m1_req = 0; m1_lock = 0; m0_we = 0; m1_we = 0;
    endtask

    typedef struct {
        bit          m0_req, m0_we, m1_req, m1_we, m1_lock;
        bit          g0, g1, we;
        logic [31:0] addr;
    } vec_t;

    vec_t vt [7];

    initial begin
        int          gc, k, run, nxt;
        bit          seen;
        int          glist [$];

        vt[0] = '{1, 0, 0, 0, 0, 1, 0, 0, 32'h10};
        vt[1] = '{0, 0, 1, 1, 0, 0, 1, 1, 32'h20};
        vt[2] = '{1, 0, 1, 1, 0, 1, 0, 0, 32'h10};
        vt[3] = '{1, 1, 1, 0, 1, 1, 0, 1, 32'h10};
        vt[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0};
        vt[5] = '{0, 1, 1, 0, 1, 0, 1, 0, 32'h20};
        vt[6] = '{1, 1, 0, 0, 0, 1, 0, 1, 32'h10};

        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        model_reset();
        rst = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_m0_rvalid", m0_rvalid, 0);
        chk("reset_m0_rdata", m0_rdata, 0);
        chk("reset_mem_en", mem_en, 0);
        rst = 1;

        // Vector table: each vector from a clean state, separated by idle.
        m0_addr = 32'h10; m0_wdata = 32'hA5A5_0001; m0_be = 4'hF;
        m1_addr = 32'h20; m1_wdata = 32'h5A5A_0002; m1_be = 4'hF;
        for (int i = 0; i < 7; i++) begin
            m0_req = vt[i].m0_req; m0_we = vt[i].m0_we;
            m1_req = vt[i].m1_req; m1_we = vt[i].m1_we; m1_lock = vt[i].m1_lock;
            step();
            chk("vec_m0_gnt", obs_g0, vt[i].g0);
            chk("vec_m1_gnt", obs_g1, vt[i].g1);
            chk("vec_mem_we", obs_we, vt[i].we);
            chk("vec_mem_addr", obs_addr, vt[i].addr);
            idle_inputs();
            step();
        end

        // Reset while a granted read is in flight.
        m0_req = 1; m0_we = 0; m0_addr = 32'h8;
        step();
        rst = 0;
        model_reset();
        #3;
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1;
        step();
        chk("post_rst_m0_rvalid", obs_rv0, 0);
        chk("post_rst_m1_rvalid", obs_rv1, 0);
        step();

        // Simple m0 read of addr 4 returning 0x2A.
        m0_req = 1; m0_we = 0; m0_addr = 32'h4;
        step();
        chk("rd4_m0_gnt", obs_g0, 1);
        idle_inputs();
        step();
        chk("rd4_m0_rvalid", obs_rv0, 1);
        chk("rd4_m0_rdata", obs_rd0, 32'h2A);
        chk("rd4_m1_rvalid", obs_rv1, 0);

        // Starvation: m0 holds the port, m1 write wins on its 5th waiting cycle.
        m0_req = 1; m0_we = 0; m0_addr = 32'h0;
        m1_req = 1; m1_we = 1; m1_addr = 32'h4; m1_wdata = 32'h7; m1_be = 4'hF; m1_lock = 0;
        gc = 0;
        for (int c = 1; c <= 8 && gc == 0; c++) begin
            step();
            if (obs_g1) begin
                gc = c;
                chk("starve_mem_we", obs_we, 1);
                chk("starve_mem_addr", obs_addr, 32'h4);
                chk("starve_mem_wdata", obs_wdata, 32'h7);
                m1_req = 0;
            end
        end
        chk("starve_grant_cycle", gc, 5);
        idle_inputs();
        step();

        // Locked burst of 10 m1 writes against a continuously requesting m0.
        m0_req = 1; m0_we = 0; m0_addr = 32'h0;
        k = 0;
        m1_req = 1; m1_we = 1; m1_lock = 1; m1_be = 4'hF;
        m1_addr = 32'h40; m1_wdata = 32'd100;
        for (int c = 0; c < 80 && k < 10; c++) begin
            step();
            if (obs_g1) begin
                glist.push_back(1);
                k++;
                m1_addr = 32'h40 + 32'(4 * k);
                m1_wdata = 32'd100 + 32'(k);
            end else if (obs_g0) begin
                glist.push_back(0);
            end
            if (k == 10) m1_req = 0;
        end
        chk("lock_writes_done", k, 10);
        run = 0; nxt = -1; seen = 0;
        foreach (glist[i]) begin
            if (!seen && glist[i] == 1) seen = 1;
            if (seen && nxt < 0) begin
                if (glist[i] == 1) run++;
                else nxt = glist[i];
            end
        end
        chk("lock_burst_len", run, MAX_LOCK);
        chk("lock_then_m0", nxt, 0);
        idle_inputs();
        step();

        // Alternating back-to-back reads with per-response routing.
        m0_req = 1; m0_we = 0; m0_addr = 32'h0;
        step();
        m0_req = 0; m1_req = 1; m1_we = 0; m1_lock = 0; m1_addr = 32'h8;
        step();
        chk("alt1_m0_rvalid", obs_rv0, 1);
        chk("alt1_m0_rdata", obs_rd0, 32'h1000);
        chk("alt1_m1_rvalid", obs_rv1, 0);
        m1_req = 0; m0_req = 1; m0_addr = 32'hC;
        step();
        chk("alt2_m1_rvalid", obs_rv1, 1);
        chk("alt2_m1_rdata", obs_rd1, 32'h1002);
        chk("alt2_m0_rvalid", obs_rv0, 0);
        idle_inputs();
        step();
        chk("alt3_m0_rvalid", obs_rv0, 1);
        chk("alt3_m0_rdata", obs_rd0, 32'h1003);

        // Random traffic; an ungranted master holds its request.
        for (int c = 0; c < 500; c++) begin
            if (!(m0_req && !exp_g0)) begin
                m0_req   = ($urandom_range(0, 9) < 7);
                m0_we    = 1'($urandom_range(0, 1));
                m0_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                m0_wdata = $urandom;
                m0_be    = 4'($urandom);
            end
            if (!(m1_req && !exp_g1)) begin
                m1_req   = ($urandom_range(0, 9) < 6);
                m1_we    = 1'($urandom_range(0, 1));
                m1_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                m1_wdata = $urandom;
                m1_be    = 4'($urandom);
                m1_lock  = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
